tape_prefetch: RTL and testbench

// - Byte prefetcher between SDRAM and the tape player. Reads tape image bytes

---
 rtl/tape_prefetch.sv | 144 ++++++++++++++
 tb/tb_tape_prefetch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tape_prefetch.sv
// tape_prefetch: fetches tape image bytes from SDRAM during Z80 refresh
// windows (nRFSH low) and queues them for the tape player. This means the
// prefetcher never takes a memory cycle away from the CPU.
//
// Ports:
//   i_clk, i_reset      system clock, asynchronous active-high reset
//   i_start, i_size     restart from byte 0 with a new image length
//   i_nRFSH             Z80 refresh strobe, active low, synchronous to i_clk
//   o_mem_rd, o_mem_addr, i_mem_din   SDRAM read leg (muxed in while nRFSH low)
//   i_pop               consumer takes the head byte
//   o_dout, o_valid     show-ahead FIFO head and non-empty flag
//   o_level             FIFO occupancy
//   o_eof               every byte of the image has been fetched and popped
module tape_prefetch #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 25,
    parameter int ACK_DELAY = 7
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [ADDR_W-1:0]          i_size,
    input  logic                       i_nRFSH,
    output logic                       o_mem_rd,
    output logic [ADDR_W-1:0]          o_mem_addr,
    input  logic [7:0]                 i_mem_din,
    input  logic                       i_pop,
    output logic [7:0]                 o_dout,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_eof
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int DLY_W = $clog2(ACK_DELAY+1);

    typedef enum logic [1:0] {IDLE, WAIT_RFSH, READ, WAIT_END} state_t;

    state_t              r_state;
    logic                r_rfsh;
    logic [DLY_W-1:0]    r_delay;
    logic [ADDR_W-1:0]   r_fetch_addr;
    logic [ADDR_W-1:0]   r_size_q;
    logic [7:0]          r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wp;
    logic [PTR_W-1:0]    r_rp;
    logic [LVL_W-1:0]    r_level;

    logic w_fall;
    logic w_push;
    logic w_pop;
    logic w_can_fetch;

    assign w_fall      = r_rfsh & ~i_nRFSH;
    // Full is checked here, at fetch start, so a push can never overflow.
    assign w_can_fetch = (r_level < LVL_W'(DEPTH)) && (r_fetch_addr < r_size_q);
    // A push happens in the last cycle of a READ. The abort check for
    // nRFSH has no effect on that cycle.
    assign w_push      = (r_state == READ) && (r_delay == DLY_W'(1)) && !i_start;
    assign w_pop       = i_pop && (r_level != '0) && !i_start;

    assign o_dout  = r_mem[r_rp];
    assign o_valid = (r_level != '0);
    assign o_level = r_level;
    assign o_eof   = (r_state != IDLE) && (r_fetch_addr == r_size_q) && (r_level == '0);

    // Fetch FSM
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_rfsh       <= 1'b1;
            r_delay      <= '0;
            r_fetch_addr <= '0;
            r_size_q     <= '0;
            o_mem_rd     <= 1'b0;
            o_mem_addr   <= '0;
        end else begin
            r_rfsh <= i_nRFSH;
            if (i_start) begin
                // Any in-flight read is dropped. Its data is never pushed.
                r_state      <= WAIT_RFSH;
                r_delay      <= '0;
                r_fetch_addr <= '0;
                r_size_q     <= i_size;
                o_mem_rd     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: ;
                    WAIT_RFSH: begin
                        if (w_fall && w_can_fetch) begin
                            o_mem_rd   <= 1'b1;
                            o_mem_addr <= r_fetch_addr;
                            r_delay    <= DLY_W'(ACK_DELAY);
                            r_state    <= READ;
                        end
                    end
                    READ: begin
                        r_delay <= r_delay - DLY_W'(1);
                        if (r_delay == DLY_W'(1)) begin
                            o_mem_rd     <= 1'b0;
                            r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
                            r_state      <= WAIT_END;
                        end else if (i_nRFSH) begin
                            // The refresh window closed too early: the address
                            // is kept and this byte is fetched again later.
                            o_mem_rd <= 1'b0;
                            r_state  <= WAIT_RFSH;
                        end
                    end
                    WAIT_END: begin
                        // At most one fetch is done per refresh window.
                        if (i_nRFSH) r_state <= WAIT_RFSH;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // FIFO. Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else if (i_start) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_mem_din;
                r_wp        <= r_wp + PTR_W'(1);
            end
            if (w_pop) r_rp <= r_rp + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tape_prefetch.sv
module tb_tape_prefetch;
    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] size;
    logic          nRFSH;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          pop;
    logic [7:0]    dout;
    logic          valid;
    logic [2:0]    level;
    logic          eof;

    int total = 0;
    int bad   = 0;
    int rd_cnt;
    logic [AW-1:0] last_addr;

    always #5 clk = ~clk;

    // SDRAM model: the byte at address a holds a+0x40
    assign mem_din = mem_addr[7:0] + 8'h40;

    tape_prefetch #(.DEPTH(4), .ADDR_W(AW), .ACK_DELAY(7)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_size(size),
        .i_nRFSH(nRFSH), .o_mem_rd(mem_rd), .o_mem_addr(mem_addr),
        .i_mem_din(mem_din), .i_pop(pop), .o_dout(dout), .o_valid(valid),
        .o_level(level), .o_eof(eof)
    );

    typedef struct {
        int            low;
        int            gap;
        int            exp_rd;
        logic [AW-1:0] exp_addr;
        int            exp_lvl;
        bit            exp_eof;
    } win_t;

    win_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample #1 after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_rd) begin
            rd_cnt++;
            last_addr = mem_addr;
        end
    endtask

    task automatic window(input int low, input int gap);
        rd_cnt = 0;
        last_addr = '1;
        nRFSH = 1'b0;
        repeat (low) tick();
        nRFSH = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic run_tbl(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            window(tbl[i].low, tbl[i].gap);
            chk($sformatf("win%0d rd_cycles", i), rd_cnt, tbl[i].exp_rd);
            if (tbl[i].exp_rd > 0)
                chk($sformatf("win%0d addr", i), 32'(last_addr), 32'(tbl[i].exp_addr));
            chk($sformatf("win%0d level", i), 32'(level), tbl[i].exp_lvl);
            chk($sformatf("win%0d valid", i), 32'(valid), 32'(tbl[i].exp_lvl != 0));
            chk($sformatf("win%0d eof", i), 32'(eof), 32'(tbl[i].exp_eof));
        end
    endtask

    task automatic do_pop(input string name, input logic [7:0] exp);
        chk(name, 32'(dout), 32'(exp));
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic do_start(input logic [AW-1:0] sz);
        start = 1'b1;
        size  = sz;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // T1 (idle), no fetches
        tbl[0]  = '{10, 30, 0, 0, 0, 0};
        tbl[1]  = '{10, 30, 0, 0, 0, 0};
        // T2 size=3
        tbl[2]  = '{10, 30, 7, 0, 1, 0};
        tbl[3]  = '{10, 30, 7, 1, 2, 0};
        tbl[4]  = '{10, 30, 7, 2, 3, 0};
        tbl[5]  = '{10, 30, 0, 0, 3, 0};
        // T3 size=10, fill the FIFO without popping
        tbl[6]  = '{10, 30, 7, 0, 1, 0};
        tbl[7]  = '{10, 30, 7, 1, 2, 0};
        tbl[8]  = '{10, 30, 7, 2, 3, 0};
        tbl[9]  = '{10, 30, 7, 3, 4, 0};
        tbl[10] = '{10, 30, 0, 0, 4, 0};
        tbl[11] = '{10, 30, 0, 0, 4, 0};
        // T4 short window aborts, next window refetches addr 0
        tbl[12] = '{4, 36, 4, 0, 0, 0};
        tbl[13] = '{10, 30, 7, 0, 1, 0};
        // T5 prefill level=2
        tbl[14] = '{10, 30, 7, 0, 1, 0};
        tbl[15] = '{10, 30, 7, 1, 2, 0};
        // T6 windows around a restart
        tbl[16] = '{10, 30, 7, 0, 1, 0};
        tbl[17] = '{10, 30, 7, 0, 1, 0};

        reset = 1'b1; start = 1'b0; size = '0; nRFSH = 1'b1; pop = 1'b0;
        rd_cnt = 0; last_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst mem_rd", 32'(mem_rd), 0);
        chk("rst mem_addr", 32'(mem_addr), 0);
        chk("rst valid", 32'(valid), 0);
        chk("rst level", 32'(level), 0);
        chk("rst eof", 32'(eof), 0);
        chk("rst dout", 32'(dout), 0);

        // T1
        run_tbl(0, 1);

        // T2
        do_start(3);
        run_tbl(2, 5);
        do_pop("t2 pop0", 8'h40);
        do_pop("t2 pop1", 8'h41);
        chk("t2 eof before last pop", 32'(eof), 0);
        do_pop("t2 pop2", 8'h42);
        chk("t2 eof", 32'(eof), 1);
        chk("t2 valid", 32'(valid), 0);

        // T3 (pointer wrap on the fifth push)
        do_start(10);
        run_tbl(6, 11);
        do_pop("t3 pop0", 8'h40);
        chk("t3 level after pop", 32'(level), 3);
        window(10, 30);
        chk("t3 refill rd_cycles", rd_cnt, 7);
        chk("t3 refill addr", 32'(last_addr), 4);
        chk("t3 refill level", 32'(level), 4);
        for (int i = 1; i <= 4; i++)
            do_pop($sformatf("t3 drain%0d", i), 8'(8'h40 + i));
        chk("t3 drained level", 32'(level), 0);

        // T4
        do_start(10);
        run_tbl(12, 13);

        // T5 push and pop in the same cycle
        do_start(10);
        run_tbl(14, 15);
        rd_cnt = 0;
        nRFSH = 1'b0;
        repeat (7) tick();
        chk("t5 mem_rd before push", 32'(mem_rd), 1);
        do_pop("t5 pop at push", 8'h40);
        chk("t5 level", 32'(level), 2);
        chk("t5 mem_rd after push", 32'(mem_rd), 0);
        repeat (2) tick();
        nRFSH = 1'b1;
        repeat (30) tick();
        chk("t5 rd_cycles", rd_cnt, 7);
        do_pop("t5 pop1", 8'h41);
        do_pop("t5 pop2", 8'h42);
        chk("t5 final level", 32'(level), 0);

        // T6 restart while a read is in flight (delay==3)
        do_start(10);
        run_tbl(16, 16);
        nRFSH = 1'b0;
        repeat (5) tick();
        chk("t6 mem_rd in read", 32'(mem_rd), 1);
        do_start(10);
        chk("t6 mem_rd after start", 32'(mem_rd), 0);
        chk("t6 level after start", 32'(level), 0);
        chk("t6 valid after start", 32'(valid), 0);
        repeat (4) tick();
        nRFSH = 1'b1;
        repeat (30) tick();
        run_tbl(17, 17);

        // Async reset during a READ takes effect before the next clock edge
        nRFSH = 1'b0;
        repeat (3) tick();
        chk("t6 mem_rd before reset", 32'(mem_rd), 1);
        #2 reset = 1'b1;
        #1;
        chk("t6 async mem_rd", 32'(mem_rd), 0);
        nRFSH = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        chk("t6 reset level", 32'(level), 0);
        chk("t6 reset eof", 32'(eof), 0);

        // size=0: eof is set in the cycle after start
        do_start(0);
        chk("size0 eof", 32'(eof), 1);
        window(10, 30);
        chk("size0 rd_cycles", rd_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
